shift_and_add_multiplier: RTL and testbench

//   Sequential unsigned shift-and-add multiplier: one partial product per clock.

---
 rtl/shift_and_add_multiplier_if.sv | 34 +++
 rtl/shift_and_add_multiplier.sv | 123 ++++++++++++
 tb/tb_shift_and_add_multiplier.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_and_add_multiplier_if.sv
// Request/response bundle of the shift-and-add multiplier.
//
// Handshake: the master raises start with operands a, b; the request is taken
// on the rising edge at which the slave is idle (busy=0) and ignored
// otherwise. Completion is a single-cycle done pulse; p holds the product
// from that cycle until the next completion or reset.
//
// Signals (WIDTH = operand width):
//   start  master->slave  1        request strobe
//   a      master->slave  WIDTH    multiplicand, unsigned
//   b      master->slave  WIDTH    multiplier, unsigned
//   busy   slave->master  1        multiplication in progress
//   done   slave->master  1        one-cycle completion pulse
//   p      slave->master  2*WIDTH  registered product
interface shift_and_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/shift_and_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mul        shift_and_add_multiplier_if.slave (start/a/b in, busy/done/p out)
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN)
//
// Optional build macro SAM_EARLY_TERM_EN: when defined, RUN ends after the
// step that leaves no set multiplier bits, so latency follows the position of
// the highest set bit of b (minimum one cycle). When undefined every product
// takes exactly WIDTH cycles. The product value is identical either way.
module shift_and_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  shift_and_add_multiplier_if.slave     mul,
  output logic                          dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mlr_q,   mlr_d;
  logic [PW-1:0]    acc_q,   acc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [PW-1:0]    p_q,     p_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [PW-1:0]    sum;
  logic             last;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mlr_d   = mlr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // mcand is shifted left once per step, so it always equals the
    // original multiplicand << cnt; no barrel shifter is needed.
    sum = acc_q + (mlr_q[0] ? mcand_q : '0);

`ifdef SAM_EARLY_TERM_EN
    // Stop once the bits still to be shifted in contribute nothing.
    last = (cnt_q == CW'(WIDTH - 1)) || (mlr_q[WIDTH-1:1] == '0);
`else
    last = (cnt_q == CW'(WIDTH - 1));
`endif

    case (state_q)
      IDLE: begin
        if (mul.start) begin
          mcand_d = {{WIDTH{1'b0}}, mul.a};
          mlr_d   = mul.b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          // Final step: the sum goes straight to p; done pulses in the
          // first IDLE cycle, where a new start can already be taken.
          p_d     = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d   = sum;
          mcand_d = mcand_q << 1;
          mlr_d   = mlr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mlr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mlr_q   <= mlr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mul.busy  = busy_q;
  assign mul.done  = done_q;
  assign mul.p     = p_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_and_add_multiplier.sv
module tb_shift_and_add_multiplier;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;
  localparam int NOPS  = 1 << (2 * WIDTH);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_and_add_multiplier_if #(.WIDTH(WIDTH)) mul_if ();

  shift_and_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul       (mul_if),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] lat_q[$];
  int n_cmp;
  int n_err;
  int exp_done;
  int done_seen;
  logic [31:0] prev_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference latency from the operand value alone.
  function automatic int exp_lat(input int bv);
    int l;
    l = WIDTH;
`ifdef SAM_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < WIDTH; i++)
      if (bv[i]) l = i + 1;
`endif
    return l;
  endfunction

  always @(negedge clk)
    if (rst_n && mul_if.done) done_seen++;

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    mul_if.start = 1'b0;
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    prev_p = 0;
  endtask

  // One isolated operation; optionally fires an extra start (ja, jb) while busy.
  task automatic run_op(input int av, input int bv, input bit junk, input int ja, input int jb);
    bit seen;
    int lat;
    logic [31:0] exp_p;
    mul_if.a = av[WIDTH-1:0];
    mul_if.b = bv[WIDTH-1:0];
    mul_if.start = 1'b1;
    exp_q.push_back(av * bv);
    lat_q.push_back(exp_lat(bv));
    exp_done++;
    @(negedge clk);
    mul_if.start = 1'b0;
    mul_if.a = WIDTH'($urandom_range(0, MAXV));
    mul_if.b = WIDTH'($urandom_range(0, MAXV));
    check("busy_after_start", mul_if.busy, 1);
    seen = 0;
    lat = 0;
    for (int i = 1; i <= 4 * WIDTH && !seen; i++) begin
      if (junk && i == 1) begin
        mul_if.a = ja[WIDTH-1:0];
        mul_if.b = jb[WIDTH-1:0];
        mul_if.start = 1'b1;
      end
      @(negedge clk);
      mul_if.start = 1'b0;
      if (mul_if.done) begin
        seen = 1;
        lat = i;
      end else begin
        check("busy_run", mul_if.busy, 1);
        check("p_hold_run", mul_if.p, prev_p);
      end
    end
    exp_p = exp_q.pop_front();
    check("done_seen", 32'(seen), 1);
    check("latency", lat, lat_q.pop_front());
    check("product", mul_if.p, exp_p);
    check("busy_at_done", mul_if.busy, 0);
    prev_p = exp_p;
    @(negedge clk);
    check("done_one_cycle", mul_if.done, 0);
    check("p_hold_idle", mul_if.p, prev_p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; exp_done = 0; done_seen = 0; prev_p = 0;
    mul_if.start = 1'b0;
    mul_if.a = '0;
    mul_if.b = '0;
    rst_n = 1'b0;
    @(negedge clk);

    do_reset(2);
    check("reset_p", mul_if.p, 0);
    check("reset_busy", mul_if.busy, 0);
    check("reset_done", mul_if.done, 0);
    check("reset_state", dbg_state, 0);

    // Directed cases, including operand boundaries.
    run_op(3, 5, 0, 0, 0);
    run_op(15, 15, 0, 0, 0);
    run_op(0, 9, 0, 0, 0);
    run_op(9, 0, 0, 0, 0);
`ifdef SAM_EARLY_TERM_EN
    run_op(5, 1, 0, 0, 0);
    run_op(5, 8, 0, 0, 0);
`endif

    // Start while busy is ignored, then a fresh start is accepted.
    run_op(6, 6, 1, 2, 7);
    run_op(2, 7, 0, 0, 0);

    // Reset in the middle of an operation.
    mul_if.a = 7; mul_if.b = 7; mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    @(negedge clk);
    do_reset(2);
    check("abort_p", mul_if.p, 0);
    check("abort_busy", mul_if.busy, 0);
    check("abort_done", mul_if.done, 0);
    repeat (WIDTH + 1) @(negedge clk);
    check("abort_no_done_p", mul_if.p, 0);
    check("abort_done_count", done_seen, exp_done);
    run_op(7, 7, 0, 0, 0);

    // Exhaustive sweep, back-to-back starts on each done.
    begin : sweep
      int idx, cyc, av, bv;
      bit go;
      mul_if.a = '0; mul_if.b = '0; mul_if.start = 1'b1;
      exp_q.push_back(0); lat_q.push_back(exp_lat(0)); exp_done++;
      idx = 1; cyc = 0; go = 1;
      while (go) begin
        @(negedge clk);
        mul_if.start = 1'b0;
        cyc++;
        if (mul_if.done) begin
          check("sweep_p", mul_if.p, exp_q.pop_front());
          check("sweep_lat", cyc - 1, lat_q.pop_front());
          cyc = 0;
          if (idx < NOPS) begin
            av = idx % (MAXV + 1);
            bv = idx / (MAXV + 1);
            mul_if.a = av[WIDTH-1:0];
            mul_if.b = bv[WIDTH-1:0];
            mul_if.start = 1'b1;
            exp_q.push_back(av * bv); lat_q.push_back(exp_lat(bv)); exp_done++;
            idx++;
          end else go = 0;
        end else if (cyc > 4 * WIDTH) begin
          check("sweep_timeout", 0, 1);
          go = 0;
        end
      end
      check("sweep_count", idx, NOPS);
      exp_q.delete();
      lat_q.delete();
      prev_p = (NOPS > 0) ? MAXV * MAXV : 0;
    end
    @(negedge clk);

    // Randomized isolated operations with random gaps and spurious starts.
    for (int k = 0; k < 40; k++) begin
      run_op($urandom_range(0, MAXV), $urandom_range(0, MAXV), 1'($urandom_range(0, 1)),
             $urandom_range(0, MAXV), $urandom_range(0, MAXV));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    check("done_count", done_seen, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
